// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store,
// data side first, with per-stage ready pulses, freeze signals and a timeout.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  output logic          if_freeze,
  input  logic          dm_r_en,
  input  logic          dm_w_en,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          dm_freeze,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);
  localparam logic [2:0] IDLE = 3'd0, BUSY_IF = 3'd1, BUSY_DM = 3'd2, RESP_IF = 3'd3, RESP_DM = 3'd4;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [2:0] st;
  logic [CW-1:0] cnt;
  logic abort, busy, done, tmo, if_abort;
  assign busy = (st == BUSY_IF) || (st == BUSY_DM);
  assign tmo = cnt == CW'(TIMEOUT - 1);
  assign done = mem_ack | tmo;
  // a redirected fetch is remembered even if the request comes back before the ack
  assign if_abort = abort | ~if_req | (if_addr != mem_addr);
  assign mem_req = busy;
  assign if_ready = st == RESP_IF;
  assign dm_ready = st == RESP_DM;
  assign if_freeze = if_req & ~if_ready;
  assign dm_freeze = (dm_r_en | dm_w_en) & ~dm_ready;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      abort <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err <= 1'b0;
    end else if (st == IDLE) begin
      cnt <= '0;
      abort <= 1'b0;
      if (dm_r_en | dm_w_en) begin
        st <= BUSY_DM;
        mem_addr <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_we <= dm_w_en;
      end else if (if_req) begin
        st <= BUSY_IF;
        mem_addr <= if_addr;
        mem_we <= 1'b0;
      end
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (st == BUSY_IF) abort <= if_abort;
      if (done) begin
        mem_we <= 1'b0;
        if (!mem_ack) err <= 1'b1;
        if (st == BUSY_DM) begin
          st <= RESP_DM;
          if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : '0;
        end else begin
          st <= if_abort ? IDLE : RESP_IF;
          if (!if_abort) if_rdata <= mem_ack ? mem_rdata : '0;
        end
      end
    end else begin
      st <= IDLE;
    end
  end
endmodule
